// File: rtl/stamper_pkg.sv
// Shared constants for the event stamper: edge-selection codes, entry width
// and the saturation limit of the dropped-event counter.
package stamper_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int CNT_W_DEF = 32;
  localparam int ENTRY_W   = 2*CNT_W_DEF + 1;
  localparam int LOST_MAX  = 255;

  // Entry layout is {timestamp, delta, first}.
  function automatic int entry_width(input int cnt_w);
    return 2*cnt_w + 1;
  endfunction

endpackage

// File: rtl/stamp_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry a wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module stamp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/param_event_stamper.sv
// Timestamps synchronized edges of evt_in against cnt_in, records the interval
// since the previous reported event and queues the result for a consumer.
module param_event_stamper
  import stamper_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   evt_in,
  input  logic                   clr_ovf,
  output logic [CNT_W-1:0]       ts_data,
  output logic [CNT_W-1:0]       ts_delta,
  output logic                   ts_first,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf,
  output logic [7:0]             lost_cnt
);

  localparam int EW = entry_width(CNT_W);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   evt_s;
  logic                   det;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   drop;
  logic [CNT_W-1:0]       last_cap;
  logic                   has_evt;
  logic [CNT_W-1:0]       delta;
  logic [EW-1:0]          wdata;
  logic [EW-1:0]          rdata;

  assign evt_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], evt_in};
      sync_prev <= evt_s;
    end
  end

  always_comb begin
    det = 1'b0;
    if (EDGE_MODE == EDGE_FALL)      det = !evt_s && sync_prev;
    else if (EDGE_MODE == EDGE_BOTH) det = evt_s ^ sync_prev;
    else                             det = evt_s && !sync_prev;
  end

  assign pop    = ts_valid && ts_ready;
  assign accept = det && (!full || pop);
  assign drop   = det && full && !pop;
  assign delta  = has_evt ? (cnt_in - last_cap) : '0;
  assign wdata  = {cnt_in, delta, !has_evt};

  // The delta reference only moves on accepted pushes, so deltas chain between reported entries.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      last_cap <= '0;
      has_evt  <= 1'b0;
    end else if (accept) begin
      last_cap <= cnt_in;
      has_evt  <= 1'b1;
    end
  end

  // A drop coinciding with a clear wins, leaving one lost event on record.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ovf      <= 1'b0;
      lost_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      if (clr_ovf)                       lost_cnt <= 8'd1;
      else if (lost_cnt != 8'(LOST_MAX)) lost_cnt <= lost_cnt + 8'd1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      lost_cnt <= '0;
    end
  end

  stamp_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (accept),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign {ts_data, ts_delta, ts_first} = rdata;
  assign ts_valid = !empty;

endmodule

// File: tb/tb_param_event_stamper.sv
// Scoreboard bench: stimulus queues expected entries, monitors compare them on
// each handshake. Instance a uses rising-edge mode, instance b both-edge mode.
module tb_param_event_stamper;
  import stamper_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] delta;
    logic        first;
  } entry_t;

  logic        clk;
  logic        rst_;
  logic [31:0] cnt_in;
  logic        evt_a, clr_a, ready_a, evt_b, clr_b, ready_b;
  logic [31:0] data_a, delta_a, data_b, delta_b;
  logic        first_a, valid_a, ovf_a, first_b, valid_b, ovf_b;
  logic [3:0]  level_a, level_b;
  logic [7:0]  lost_a, lost_b;

  int          n_checks;
  int          n_fail;
  entry_t      exp_a[$];
  entry_t      exp_b[$];
  entry_t      mon_a;
  entry_t      mon_b;
  logic [31:0] last_a, last_b;
  logic        has_a, has_b;

  param_event_stamper #(.CNT_W(32), .DEPTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE)) dut_a (
    .clk(clk), .rst_(rst_), .cnt_in(cnt_in), .evt_in(evt_a), .clr_ovf(clr_a),
    .ts_data(data_a), .ts_delta(delta_a), .ts_first(first_a), .ts_valid(valid_a),
    .ts_ready(ready_a), .fifo_level(level_a), .ovf(ovf_a), .lost_cnt(lost_a)
  );

  param_event_stamper #(.CNT_W(32), .DEPTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_BOTH)) dut_b (
    .clk(clk), .rst_(rst_), .cnt_in(cnt_in), .evt_in(evt_b), .clr_ovf(clr_b),
    .ts_data(data_b), .ts_delta(delta_b), .ts_first(first_b), .ts_valid(valid_b),
    .ts_ready(ready_b), .fifo_level(level_b), .ovf(ovf_b), .lost_cnt(lost_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cnt_in = cnt_in + 32'd1;
  endtask

  // Drives the event line; the capture lands two edges later, when cnt_in has advanced by 2.
  task automatic applyStimulus(input bit on_b, input logic lvl, input bit accepted);
    entry_t      e;
    logic [31:0] cap;
    cap = cnt_in + 32'd2;
    if (on_b) begin
      evt_b = lvl;
      if (accepted) begin
        e.data  = cap;
        e.delta = has_b ? cap - last_b : 32'd0;
        e.first = !has_b;
        last_b  = cap;
        has_b   = 1'b1;
        exp_b.push_back(e);
      end
    end else begin
      evt_a = lvl;
      if (accepted) begin
        e.data  = cap;
        e.delta = has_a ? cap - last_a : 32'd0;
        e.first = !has_a;
        last_a  = cap;
        has_a   = 1'b1;
        exp_a.push_back(e);
      end
    end
  endtask

  task automatic pulse_a(input bit accepted);
    tick();
    applyStimulus(1'b0, 1'b1, accepted);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain(input bit on_b);
    repeat (4) tick();
    if (on_b) begin
      ready_b = 1'b1;
      for (int i = 0; i < 40 && valid_b; i++) tick();
      ready_b = 1'b0;
      checkOutput("drain_b_empty", valid_b, 0);
    end else begin
      ready_a = 1'b1;
      for (int i = 0; i < 40 && valid_a; i++) tick();
      ready_a = 1'b0;
      checkOutput("drain_a_empty", valid_a, 0);
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    if (valid_a && ready_a) begin
      checkOutput("a_expected_entry", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        mon_a = exp_a.pop_front();
        checkOutput("a_ts_data", data_a, mon_a.data);
        checkOutput("a_ts_delta", delta_a, mon_a.delta);
        checkOutput("a_ts_first", first_a, mon_a.first);
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (valid_b && ready_b) begin
      checkOutput("b_expected_entry", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        mon_b = exp_b.pop_front();
        checkOutput("b_ts_data", data_b, mon_b.data);
        checkOutput("b_ts_delta", delta_b, mon_b.delta);
        checkOutput("b_ts_first", first_b, mon_b.first);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_     = 1'b0;
    cnt_in   = 32'd99;
    evt_a = 1'b0; clr_a = 1'b0; ready_a = 1'b0;
    evt_b = 1'b0; clr_b = 1'b0; ready_b = 1'b0;
    has_a = 1'b0; has_b = 1'b0; last_a = '0; last_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ts_valid", valid_a, 0);
    checkOutput("reset_fifo_level", level_a, 0);
    checkOutput("reset_ovf", ovf_a, 0);
    checkOutput("reset_lost_cnt", lost_a, 0);
    checkOutput("reset_ts_data", data_a, 0);
    checkOutput("reset_ts_delta", delta_a, 0);
    checkOutput("reset_ts_first", first_a, 0);
    checkOutput("reset_b_ts_valid", valid_b, 0);
    rst_ = 1'b1;

    // Single rising event and its output latency.
    repeat (9) tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("latency_not_yet_valid", valid_a, 0);
    tick();
    checkOutput("latency_valid", valid_a, 1);
    checkOutput("single_level", level_a, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain(1'b0);

    // Counter wrap between two events.
    tick();
    cnt_in = 32'hFFFF_FFEE;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    cnt_in = 32'h0000_000E;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain(1'b0);

    // Ten events into an undrained FIFO: two are dropped.
    for (int i = 0; i < 10; i++) pulse_a(i < 8);
    repeat (3) tick();
    checkOutput("full_level", level_a, 8);
    checkOutput("full_ovf", ovf_a, 1);
    checkOutput("full_lost_cnt", lost_a, 2);

    // Full FIFO with a pop in the detect cycle: push accepted, no drop.
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    checkOutput("simul_level", level_a, 8);
    checkOutput("simul_lost_cnt", lost_a, 2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain(1'b0);

    // Both-edge mode: a 3-cycle pulse gives two entries, the second with delta 3.
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      tick();
      applyStimulus(1'b1, ~evt_b, 1'b1);
    end
    repeat (3) tick();
    checkOutput("b_full_level", level_b, 8);
    for (int i = 0; i < 300; i++) begin
      tick();
      tick();
      applyStimulus(1'b1, ~evt_b, 1'b0);
    end
    repeat (3) tick();
    checkOutput("b_lost_saturated", lost_b, 255);
    checkOutput("b_ovf_set", ovf_b, 1);
    tick();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checkOutput("b_clr_ovf", ovf_b, 0);
    checkOutput("b_clr_lost_cnt", lost_b, 0);
    tick();
    tick();
    applyStimulus(1'b1, ~evt_b, 1'b0);
    tick();
    tick();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checkOutput("b_clr_vs_drop_lost", lost_b, 1);
    checkOutput("b_clr_vs_drop_ovf", ovf_b, 1);
    drain(1'b1);

    // Reset with five entries queued.
    for (int i = 0; i < 5; i++) pulse_a(1'b1);
    repeat (3) tick();
    checkOutput("pre_reset_level", level_a, 5);
    tick();
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    exp_a.delete();
    exp_b.delete();
    has_a = 1'b0;
    has_b = 1'b0;
    checkOutput("mid_reset_ts_valid", valid_a, 0);
    checkOutput("mid_reset_level", level_a, 0);
    checkOutput("mid_reset_ovf", ovf_a, 0);
    pulse_a(1'b1);
    drain(1'b0);

    checkOutput("a_scoreboard_empty", exp_a.size(), 0);
    checkOutput("b_scoreboard_empty", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_event_stamper.md
# param_event_stamper

Timestamps asynchronous events against the free-running 32-bit count bus from `param_counter`. Each event is captured together with the interval since the previously reported event and queued in a small FIFO. Software or a downstream DMA stage drains the FIFO through a valid/ready handshake. The block is the direct consumer of the counter output `q`.

## Interface
- `CNT_W`, 32: width of the count bus and of the timestamp and delta fields.
- `DEPTH`, 8: FIFO entries; must be a power of two and at least 2.
- `SYNC_STAGES`, 2: synchronizer flops on `evt_in`; at least 2.
- `EDGE_MODE`, 0: event edge selection; 0 = rising, 1 = falling, 2 = both.

- `clk` in 1: clock; reset `rst_`, asynchronous, active-low; clock `clk`.
- `rst_` in 1: asynchronous active-low reset.
- `cnt_in` in `CNT_W`: count value, treated as an opaque free-running value.
- `evt_in` in 1: asynchronous event line.
- `clr_ovf` in 1: synchronous pulse; clears `ovf` and `lost_cnt`.
- `ts_data` out `CNT_W`: captured count at the head entry.
- `ts_delta` out `CNT_W`: interval to the previous accepted event at the head entry.
- `ts_first` out 1: head entry is the first accepted event since reset.
- `ts_valid` out 1: head entry present.
- `ts_ready` in 1: consumer accepts the head entry.
- `fifo_level` out `$clog2(DEPTH)+1`: number of occupied entries, 0..`DEPTH`.
- `ovf` out 1: sticky flag; at least one event was dropped.
- `lost_cnt` out 8: dropped-event count; saturates at 255.

## Operation
- **Synchronizer and edge detect.** `evt_in` passes through `SYNC_STAGES` flops. A further flop holds the previous synchronized value. `det` is asserted for exactly one cycle per selected edge.
- **Capture.** In the cycle `det` is high, `cap = cnt_in`.
  - `delta = cap - last_cap`, modulo 2^`CNT_W`; wrap-around yields the correct unsigned difference.
  - If no event has been accepted since reset, `delta = 0` and `first = 1`.
- **Push accepted** when `det` is high and either the FIFO is not full or a pop occurs in the same cycle.
  - The entry `{cap, delta, first}` is written.
  - `last_cap` and the has-event flag update only on an accepted push, so `delta` always refers to the previous reported entry.
- **Push dropped** when `det` is high, the FIFO is full and there is no pop.
  - The entry is discarded and `last_cap` is unchanged.
  - `ovf` is set to 1 and `lost_cnt` is incremented, saturating at 255.
- **Pop.** A pop occurs when `ts_valid && ts_ready`. The head advances at the clock edge.
- **Simultaneous push and pop.**
  - `fifo_level` is unchanged.
  - When the FIFO is full this counts as an accepted push.
  - When the FIFO is empty the push lands and `ts_valid` rises next cycle; there is no bypass.
- **Overflow clear.** When `clr_ovf` coincides with a drop, the drop wins: `ovf = 1` and `lost_cnt = 1`.
- **Reset values.** All outputs are 0: `ts_valid = 0`, `fifo_level = 0`, `ovf = 0`, `lost_cnt = 0`, `ts_data`/`ts_delta`/`ts_first` = 0. The synchronizer flops, the previous-value flop, `last_cap` and the has-event flag are also cleared.
  - Because of the cleared previous-value flop, an `evt_in` already high at reset release produces a rising `det` in rising or both mode.
- **Reset mid-operation.** All queued entries are lost and the next accepted event is reported with `first = 1`.

## Timing
- **Event latency.** `evt_in` is sampled at edge k. `det` is high during the cycle after edge k+`SYNC_STAGES`-1, and `cnt_in` is captured at edge k+`SYNC_STAGES`.
- **Output latency.** `ts_valid` rises after edge k+`SYNC_STAGES` when the FIFO was empty. With the default this is 2 cycles from the sampling edge.
- **Handshake.**
  - `ts_data`, `ts_delta` and `ts_first` are head-of-FIFO values from registered storage.
  - They are stable while `ts_valid && !ts_ready`.
  - `ts_valid` never drops without a pop.
  - Throughput is 1 entry per cycle.
- **Minimum event spacing.** Each selected edge is captured individually, provided the input stays at each level for at least 1 `clk` cycle.
- **Counters.** `fifo_level`, `ovf` and `lost_cnt` are registered and update at the same edge as the push or pop.

## Structure
- **Package `stamper_pkg`:**
  - `EDGE_RISE = 0`, `EDGE_FALL = 1`, `EDGE_BOTH = 2`.
  - Entry struct/width constant: `ENTRY_W = 2*CNT_W + 1`.
  - `LOST_MAX = 255`.
- **Sub-module `stamp_fifo`:**
  - Synchronous, first-word-fall-through, parameterized `WIDTH`/`DEPTH`.
  - Pointers carry an extra wrap bit.
  - Outputs `full`, `empty` and `level`.
- **Top level:** synchronizer, edge detect, delta subtractor and overflow logic.

## Test plan
- **Single rising event.** `cnt_in` ramps +1 per cycle from 100 and `evt_in` rises at cycle 10. Required: one entry with `ts_first = 1` and `ts_delta = 0`; `ts_valid` high 2 cycles after the sampling edge; `ts_data` equals `cnt_in` at the capture edge.
- **Counter wrap.** Events captured at counts `0xFFFFFFF0` and `0x00000010`. Required: second entry has `ts_delta = 0x20` and `ts_first = 0`.
- **Full FIFO, no drain.** With `ts_ready = 0`, send 10 events with `DEPTH = 8`. Required: `fifo_level = 8`, `ovf = 1`, `lost_cnt = 2`; the 8 stored entries are the first 8 events; the 9th entry's delta is measured from event 8.
- **Full FIFO, simultaneous push and pop.** FIFO full, `ts_ready = 1` and `det` high in the same cycle. Required: no drop, `fifo_level` stays 8, `lost_cnt` unchanged.
- **Both-edge mode and overflow clear.** `EDGE_MODE = 2`, with a pulse 3 cycles wide. Required: two entries, the second with `ts_delta = 3`. Then drive 300 drops. Required: `lost_cnt = 255`; after a `clr_ovf` pulse, `ovf = 0` and `lost_cnt = 0`.
- **Reset mid-operation.** Hold 5 entries queued, then assert `rst_` low for 1 cycle. Required: `ts_valid = 0` and `fifo_level = 0`; the next event is reported with `ts_first = 1` and `ts_delta = 0`.
